// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-lite controller: FSM states, ALU/extender codes, opcodes and functs.
// Latency: n/a (constants only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

  // FSM state codes; these values are visible on the state output.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Coarse instruction class; it chooses the path through the FSM.
  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_BEQ   = 3'd1,
    CLS_BNE   = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STORE = 3'd4,
    CLS_J     = 3'd5,
    CLS_JAL   = 3'd6,
    CLS_JR    = 3'd7
  } instr_cls_e;

  // ALU operation codes understood by the datapath ALU.
  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_ADD  = 5'd2;
  localparam logic [4:0] ALUOp_SUBU = 5'd3;
  localparam logic [4:0] ALUOp_SUB  = 5'd4;
  localparam logic [4:0] ALUOp_AND  = 5'd5;
  localparam logic [4:0] ALUOp_OR   = 5'd6;
  localparam logic [4:0] ALUOp_SLT  = 5'd7;
  localparam logic [4:0] ALUOp_SLL  = 5'd8;
  localparam logic [4:0] ALUOp_SRL  = 5'd9;
  localparam logic [4:0] ALUOp_SRA  = 5'd10;

  // Immediate extender modes.
  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  // PC source select and branch-type codes.
  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_JR   = 2'b11;
  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_BEQ   = 2'b01;
  localparam logic [1:0] BR_BNE   = 2'b10;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// Per-instruction field decode: ALU op, extender mode, ALU B source, dest select, class and legality.
// Latency: purely combinational.
// Backpressure: none; outputs follow OpCode/Funct directly.
module instr_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  output logic [4:0]  aluctrl_o,
  output logic [1:0]  extop_o,
  output logic        alusrc_o,
  output logic        regdst_o,
  output instr_cls_e  cls_o,
  output logic        legal_o
);

  // Table lookup on opcode, then on funct for R-type; unknown encodings clear legal_o.
  always_comb begin
    aluctrl_o = ALUOp_NOP;
    extop_o   = EXT_ZERO;
    alusrc_o  = 1'b0;
    regdst_o  = 1'b1;
    cls_o     = CLS_ALU;
    legal_o   = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        regdst_o = 1'b0;
        case (funct_i)
          FN_ADDU: aluctrl_o = ALUOp_ADDU;
          FN_ADD:  aluctrl_o = ALUOp_ADD;
          FN_SUBU: aluctrl_o = ALUOp_SUBU;
          FN_SUB:  aluctrl_o = ALUOp_SUB;
          FN_SLT:  aluctrl_o = ALUOp_SLT;
          FN_SLL:  aluctrl_o = ALUOp_SLL;
          FN_SRL:  aluctrl_o = ALUOp_SRL;
          FN_SRA:  aluctrl_o = ALUOp_SRA;
          FN_AND:  aluctrl_o = ALUOp_AND;
          FN_OR:   aluctrl_o = ALUOp_OR;
          FN_JR:   cls_o     = CLS_JR;
          default: legal_o   = 1'b0;
        endcase
      end
      OP_ORI:  begin aluctrl_o = ALUOp_OR;  extop_o = EXT_ZERO;    alusrc_o = 1'b1; end
      OP_LUI:  begin aluctrl_o = ALUOp_OR;  extop_o = EXT_HIGHPOS; alusrc_o = 1'b1; end
      OP_SLTI: begin aluctrl_o = ALUOp_SLT; extop_o = EXT_SIGNED;  alusrc_o = 1'b1; end
      OP_ADDI: begin aluctrl_o = ALUOp_ADD; extop_o = EXT_SIGNED;  alusrc_o = 1'b1; end
      OP_LW: begin
        aluctrl_o = ALUOp_ADD; extop_o = EXT_SIGNED; alusrc_o = 1'b1; cls_o = CLS_LOAD;
      end
      OP_SW: begin
        aluctrl_o = ALUOp_ADD; extop_o = EXT_SIGNED; alusrc_o = 1'b1; cls_o = CLS_STORE;
      end
      OP_BEQ:  begin aluctrl_o = ALUOp_SUB; extop_o = EXT_SIGNED; cls_o = CLS_BEQ; end
      OP_BNE:  begin aluctrl_o = ALUOp_SUB; extop_o = EXT_SIGNED; cls_o = CLS_BNE; end
      OP_J:    cls_o = CLS_J;
      OP_JAL:  cls_o = CLS_JAL;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-lite control FSM (FETCH/DECODE/EXEC/MEM/WB) with a memory wait-timeout counter.
// Latency: J/JAL/JR 2 cycles, BEQ/BNE 3, SW and ALU ops 4, LW 5 when mem_ready is always high.
// Backpressure: FETCH and MEM stall on mem_ready low; after MEM_TIMEOUT low cycles the access aborts with bus_err.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegDst,
  output logic       MemR,
  output logic       Mem2R,
  output logic       MemW,
  output logic       RegW,
  output logic       Alusrc,
  output logic [1:0] jump,
  output logic [1:0] Branch,
  output logic [1:0] EXTOp,
  output logic [4:0] Aluctrl,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err
);

  localparam int             CW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  TMO = CW'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d, wait_inc;
  logic            timeout;

  logic [4:0]      dec_alu;
  logic [1:0]      dec_ext;
  logic            dec_alusrc, dec_regdst, dec_legal;
  instr_cls_e      dec_cls;

  instr_decode u_dec (
    .opcode_i  (OpCode),
    .funct_i   (Funct),
    .aluctrl_o (dec_alu),
    .extop_o   (dec_ext),
    .alusrc_o  (dec_alusrc),
    .regdst_o  (dec_regdst),
    .cls_o     (dec_cls),
    .legal_o   (dec_legal)
  );

  // Abort when this low-ready cycle would bring the wait count up to MEM_TIMEOUT;
  // a ready on that same cycle wins and completes the access normally.
  assign wait_inc = wait_q + CW'(1);
  assign timeout  = !mem_ready && (wait_inc == TMO);
  assign state    = state_q;

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state and control outputs; the counter only survives while stalled in FETCH or MEM.
  always_comb begin
    state_d = ST_FETCH;
    wait_d  = '0;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RegDst  = 1'b0;
    MemR    = 1'b0;
    Mem2R   = 1'b0;
    MemW    = 1'b0;
    RegW    = 1'b0;
    Alusrc  = 1'b0;
    jump    = JMP_NONE;
    Branch  = BR_NONE;
    EXTOp   = EXT_ZERO;
    Aluctrl = ALUOp_NOP;
    illegal = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemR = 1'b1;
        if (mem_ready) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;               // refetch from the unchanged PC
        end else begin
          state_d = ST_FETCH;
          wait_d  = wait_inc;
        end
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          illegal = 1'b1;
        end else begin
          case (dec_cls)
            CLS_J:   begin jump = JMP_J;   PCWr = 1'b1; end
            CLS_JAL: begin jump = JMP_JAL; PCWr = 1'b1; RegW = 1'b1; end
            CLS_JR:  begin jump = JMP_JR;  PCWr = 1'b1; end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        Alusrc  = dec_alusrc;
        EXTOp   = dec_ext;
        Aluctrl = dec_alu;
        case (dec_cls)
          CLS_BEQ:             Branch  = BR_BEQ;
          CLS_BNE:             Branch  = BR_BNE;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        MemR = (dec_cls == CLS_LOAD);
        MemW = (dec_cls == CLS_STORE);
        if (mem_ready) begin
          state_d = (dec_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          bus_err = 1'b1;
        end else begin
          state_d = ST_MEM;
          wait_d  = wait_inc;
        end
      end
      ST_WB: begin
        RegW   = 1'b1;
        RegDst = dec_regdst;
        Mem2R  = (dec_cls == CLS_LOAD);
      end
      default: ;                        // unused codes fall back to FETCH with outputs idle
    endcase
    // A reset cycle abandons the instruction: no architectural write or event pulse escapes.
    if (rst) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = BR_NONE;
      illegal = 1'b0;
      bus_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction expected cycle sequences built from instruction rules.
// Latency: n/a.
// Backpressure: mem_ready wait patterns (including timeouts) are chosen per instruction.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OpCode, Funct;
  logic       mem_ready;
  logic       PCWr, IRWr, RegDst, MemR, Mem2R, MemW, RegW, Alusrc;
  logic [1:0] jump, Branch, EXTOp;
  logic [4:0] Aluctrl;
  logic [2:0] state;
  logic       illegal, bus_err;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWr(PCWr), .IRWr(IRWr), .RegDst(RegDst), .MemR(MemR), .Mem2R(Mem2R),
    .MemW(MemW), .RegW(RegW), .Alusrc(Alusrc), .jump(jump), .Branch(Branch),
    .EXTOp(EXTOp), .Aluctrl(Aluctrl), .state(state), .illegal(illegal), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic pcwr, irwr, regdst, memr, mem2r, memw, regw, alusrc;
    logic [1:0] jump, branch, ext;
    logic [4:0] alu;
    logic ill, berr;
  } obs_t;

  typedef enum {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_ILL} kind_e;
  typedef struct {
    string nm; logic [5:0] op, fn; kind_e k; logic [4:0] alu; logic [1:0] ext; logic src;
  } ins_t;
  typedef struct { string nm; logic [5:0] op, fn; logic rdy; obs_t exp; } cyc_t;

  obs_t  obs;
  ins_t  tbl[$];
  cyc_t  q[$];
  int    errors = 0, checks = 0, cyc_no = 0;

  assign obs = {state, PCWr, IRWr, RegDst, MemR, Mem2R, MemW, RegW, Alusrc,
                jump, Branch, EXTOp, Aluctrl, illegal, bus_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.alu = ALUOp_NOP;
    return o;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rndb();
    return 1'($urandom);
  endfunction

  task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input kind_e k,
                     input logic [4:0] alu, input logic [1:0] ext, input logic src);
    ins_t t;
    t.nm = nm; t.op = op; t.fn = fn; t.k = k; t.alu = alu; t.ext = ext; t.src = src;
    tbl.push_back(t);
  endtask

  function automatic ins_t get(input string nm);
    foreach (tbl[i]) if (tbl[i].nm == nm) return tbl[i];
    return tbl[0];
  endfunction

  task automatic push(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input obs_t e);
    cyc_t c;
    c.nm = nm; c.op = op; c.fn = fn; c.rdy = rdy; c.exp = e;
    q.push_back(c);
  endtask

  // Expected cycle sequence for one instruction: ftmo aborted fetches, fw low cycles before the
  // fetch completes, then either a timed-out memory access or mw low cycles before ready.
  task automatic build(input ins_t in, input int ftmo, input int fw, input bit mtmo, input int mw);
    obs_t e;
    logic [5:0] fn;
    bit mem;
    fn  = (in.op == 6'h00) ? in.fn : rnd6();
    mem = (in.k == K_LW) || (in.k == K_SW);
    for (int a = 0; a < ftmo; a++)
      for (int i = 0; i < TO; i++) begin
        e = base(3'd0); e.memr = 1'b1; e.berr = (i == TO - 1);
        push(in.nm, rnd6(), rnd6(), 1'b0, e);
      end
    for (int i = 0; i < fw; i++) begin
      e = base(3'd0); e.memr = 1'b1;
      push(in.nm, rnd6(), rnd6(), 1'b0, e);
    end
    e = base(3'd0); e.memr = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    push(in.nm, rnd6(), rnd6(), 1'b1, e);
    e = base(3'd1);
    case (in.k)
      K_J:     begin e.jump = 2'b01; e.pcwr = 1'b1; end
      K_JAL:   begin e.jump = 2'b10; e.pcwr = 1'b1; e.regw = 1'b1; end
      K_JR:    begin e.jump = 2'b11; e.pcwr = 1'b1; end
      K_ILL:   e.ill = 1'b1;
      default: ;
    endcase
    push(in.nm, in.op, fn, rndb(), e);
    if (in.k inside {K_J, K_JAL, K_JR, K_ILL}) return;
    e = base(3'd2); e.alu = in.alu; e.ext = in.ext; e.alusrc = in.src;
    if (in.k == K_BEQ) e.branch = 2'b01;
    if (in.k == K_BNE) e.branch = 2'b10;
    push(in.nm, in.op, fn, rndb(), e);
    if (in.k == K_BEQ || in.k == K_BNE) return;
    if (mem) begin
      for (int i = 0; i < (mtmo ? TO : mw); i++) begin
        e = base(3'd3); e.memr = (in.k == K_LW); e.memw = (in.k == K_SW);
        e.berr = mtmo && (i == TO - 1);
        push(in.nm, in.op, fn, 1'b0, e);
      end
      if (mtmo) return;
      e = base(3'd3); e.memr = (in.k == K_LW); e.memw = (in.k == K_SW);
      push(in.nm, in.op, fn, 1'b1, e);
      if (in.k == K_SW) return;
    end
    e = base(3'd4); e.regw = 1'b1; e.regdst = (in.op != 6'h00); e.mem2r = (in.k == K_LW);
    push(in.nm, in.op, fn, rndb(), e);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_t c;
      c = q.pop_front();
      OpCode = c.op; Funct = c.fn; mem_ready = c.rdy;
      @(negedge clk);
      check($sformatf("%s/cyc%0d/st%0d", c.nm, cyc_no, c.exp.st), 32'(obs), 32'(c.exp));
      cyc_no++;
      @(posedge clk); #1;
    end
  endtask

  // Assert rst on record n of an instruction: strobes must be quiet, then FETCH follows.
  task automatic reset_at(input string nm, input int mw, input int n);
    cyc_t c;
    obs_t e;
    build(get(nm), 0, 0, 1'b0, mw);
    run_n(n);
    c = q.pop_front();
    q.delete();
    e = c.exp;
    e.pcwr = 1'b0; e.irwr = 1'b0; e.regw = 1'b0; e.memw = 1'b0;
    e.branch = 2'b00; e.ill = 1'b0; e.berr = 1'b0;
    OpCode = c.op; Funct = c.fn; mem_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    check({"rst_in_", nm}, 32'(obs), 32'(e));
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    e = base(3'd0); e.memr = 1'b1;
    check({"post_rst_", nm}, 32'(obs), 32'(e));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    rst = 1'b1; OpCode = '0; Funct = '0; mem_ready = 1'b1;
    add("ADDU", OP_RTYPE, FN_ADDU, K_ALU, ALUOp_ADDU, EXT_ZERO, 1'b0);
    add("ADD",  OP_RTYPE, FN_ADD,  K_ALU, ALUOp_ADD,  EXT_ZERO, 1'b0);
    add("SUBU", OP_RTYPE, FN_SUBU, K_ALU, ALUOp_SUBU, EXT_ZERO, 1'b0);
    add("SUB",  OP_RTYPE, FN_SUB,  K_ALU, ALUOp_SUB,  EXT_ZERO, 1'b0);
    add("SLT",  OP_RTYPE, FN_SLT,  K_ALU, ALUOp_SLT,  EXT_ZERO, 1'b0);
    add("SLL",  OP_RTYPE, FN_SLL,  K_ALU, ALUOp_SLL,  EXT_ZERO, 1'b0);
    add("SRL",  OP_RTYPE, FN_SRL,  K_ALU, ALUOp_SRL,  EXT_ZERO, 1'b0);
    add("SRA",  OP_RTYPE, FN_SRA,  K_ALU, ALUOp_SRA,  EXT_ZERO, 1'b0);
    add("AND",  OP_RTYPE, FN_AND,  K_ALU, ALUOp_AND,  EXT_ZERO, 1'b0);
    add("OR",   OP_RTYPE, FN_OR,   K_ALU, ALUOp_OR,   EXT_ZERO, 1'b0);
    add("JR",   OP_RTYPE, FN_JR,   K_JR,  ALUOp_NOP,  EXT_ZERO, 1'b0);
    add("ORI",  OP_ORI,   6'h00,   K_ALU, ALUOp_OR,   EXT_ZERO,    1'b1);
    add("LUI",  OP_LUI,   6'h00,   K_ALU, ALUOp_OR,   EXT_HIGHPOS, 1'b1);
    add("SLTI", OP_SLTI,  6'h00,   K_ALU, ALUOp_SLT,  EXT_SIGNED,  1'b1);
    add("ADDI", OP_ADDI,  6'h00,   K_ALU, ALUOp_ADD,  EXT_SIGNED,  1'b1);
    add("LW",   OP_LW,    6'h00,   K_LW,  ALUOp_ADD,  EXT_SIGNED,  1'b1);
    add("SW",   OP_SW,    6'h00,   K_SW,  ALUOp_ADD,  EXT_SIGNED,  1'b1);
    add("BEQ",  OP_BEQ,   6'h00,   K_BEQ, ALUOp_SUB,  EXT_SIGNED,  1'b0);
    add("BNE",  OP_BNE,   6'h00,   K_BNE, ALUOp_SUB,  EXT_SIGNED,  1'b0);
    add("J",    OP_J,     6'h00,   K_J,   ALUOp_NOP,  EXT_ZERO,    1'b0);
    add("JAL",  OP_JAL,   6'h00,   K_JAL, ALUOp_NOP,  EXT_ZERO,    1'b0);
    add("ILL3F",  6'h3F,    6'h00, K_ILL, ALUOp_NOP, EXT_ZERO, 1'b0);
    add("ILL01",  6'h01,    6'h00, K_ILL, ALUOp_NOP, EXT_ZERO, 1'b0);
    add("ILL0C",  6'h0C,    6'h00, K_ILL, ALUOp_NOP, EXT_ZERO, 1'b0);
    add("ILLNOR", OP_RTYPE, 6'h27, K_ILL, ALUOp_NOP, EXT_ZERO, 1'b0);

    // Reset: strobes stay quiet while rst is high, then idle FETCH with only MemR.
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = base(3'd0); e.memr = 1'b1;
    check("rst_hold", 32'(obs), 32'(e));
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("post_rst", 32'(obs), 32'(e));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed sequences.
    build(get("ADDU"), 0, 0, 1'b0, 0);
    build(get("LW"),   0, 0, 1'b0, 3);
    build(get("BNE"),  0, 0, 1'b0, 0);
    build(get("JAL"),  0, 0, 1'b0, 0);
    build(get("SW"),   0, 0, 1'b1, 0);
    build(get("SW"),   0, 0, 1'b0, TO - 1);
    build(get("ILL3F"), 0, 0, 1'b0, 0);
    build(get("ADDI"), 1, TO - 1, 1'b0, 0);
    build(get("LW"),   0, 1, 1'b1, 0);
    build(get("J"),    0, 0, 1'b0, 0);
    build(get("JR"),   0, 0, 1'b0, 0);
    build(get("BEQ"),  0, 0, 1'b0, 0);
    run_n(q.size());

    // Reset in MEM (store), WB (load) and DECODE (JAL).
    reset_at("SW", 3, 4);
    reset_at("LW", 0, 4);
    reset_at("JAL", 0, 1);

    // Random instruction stream with random stalls and occasional timeouts.
    for (int n = 0; n < 150; n++) begin
      build(tbl[$urandom_range(0, tbl.size() - 1)],
            ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, TO - 1),
            ($urandom_range(0, 5) == 0), $urandom_range(0, TO - 1));
      run_n(q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
